// File: rtl/alu_bool_pipe.sv
// alu_bool_pipe: two-stage pipelined bitwise ALU with a valid/ready
// handshake on both sides and a global enable.
//   Stage 1 registers the operands and opcode.
//   Stage 2 registers the computed result together with its zero, parity
//   and illegal-opcode flags.
// The flags are derived from the same combinational result that is
// written into the stage-2 result register, so they always describe the
// value presented on the result port.
module alu_bool_pipe #(
  parameter int WIDTH          = 32,
  parameter int ERR_ON_ILLEGAL = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       opcode,
  input  logic             en,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             parity,
  output logic             err,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam logic [2:0] OP_XOR  = 3'b000;
  localparam logic [2:0] OP_AND  = 3'b001;
  localparam logic [2:0] OP_OR   = 3'b010;
  localparam logic [2:0] OP_XNOR = 3'b011;
  localparam logic [2:0] OP_NAND = 3'b100;
  localparam logic [2:0] OP_NOR  = 3'b101;
  localparam logic [2:0] OP_ANDN = 3'b110;
  localparam logic [2:0] OP_ILL  = 3'b111;

  // Bitwise operation select; the illegal opcode yields an all-zero word.
  function automatic logic [WIDTH-1:0] f_alu(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    logic [WIDTH-1:0] r;
    r = '0;
    case (op)
      OP_XOR:  r = a ^ b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XNOR: r = ~(a ^ b);
      OP_NAND: r = ~(a & b);
      OP_NOR:  r = ~(a | b);
      OP_ANDN: r = a & ~b;
      default: r = '0;
    endcase
    return r;
  endfunction

  // Illegal-opcode flag, suppressed entirely when the parameter disables it.
  function automatic logic f_err(input logic [2:0] op);
    return (ERR_ON_ILLEGAL != 0) && (op == OP_ILL);
  endfunction

  // Stage 1 state
  logic             r_vld_p1;
  logic [WIDTH-1:0] r_a_p1;
  logic [WIDTH-1:0] r_b_p1;
  logic [2:0]       r_op_p1;

  // Stage 2 state
  logic             r_vld_p2;
  logic [WIDTH-1:0] r_res_p2;
  logic             r_zero_p2;
  logic             r_par_p2;
  logic             r_err_p2;

  // Handshake / advance controls
  logic             w_s2_adv;
  logic             w_s1_adv;
  logic [WIDTH-1:0] w_res_p1;
  logic             w_zero_p1;
  logic             w_par_p1;
  logic             w_err_p1;

  // Stage 2 may take a new word when enabled and either empty or draining
  // this cycle; stage 1 may take a new word when enabled and either empty
  // or moving into stage 2. Reset blocks acceptance.
  assign w_s2_adv = en & (~r_vld_p2 | out_ready);
  assign w_s1_adv = en & (~r_vld_p1 | w_s2_adv);
  assign in_ready = w_s1_adv & ~rst;

  // Combinational compute between the two register stages.
  assign w_res_p1  = f_alu(r_op_p1, r_a_p1, r_b_p1);
  assign w_zero_p1 = ~(|w_res_p1);
  assign w_par_p1  = ^w_res_p1;
  assign w_err_p1  = f_err(r_op_p1);

  // ---- stage 1 boundary: operand capture ----
  // Stage-1 valid: cleared by reset, otherwise follows in_valid on advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p1 <= 1'b0;
    end else if (w_s1_adv) begin
      r_vld_p1 <= in_valid;
    end
  end

  // Stage-1 operands: loaded only for real transfers; bubbles leave them.
  always_ff @(posedge clk) begin
    if (w_s1_adv && in_valid) begin
      r_a_p1  <= A;
      r_b_p1  <= B;
      r_op_p1 <= opcode;
    end
  end

  // ---- stage 2 boundary: result and flags ----
  // Stage-2 valid and output word: zeroed by reset, loaded from stage 1 on
  // advance; a bubble only clears valid so the last word stays visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p2  <= 1'b0;
      r_res_p2  <= '0;
      r_zero_p2 <= 1'b0;
      r_par_p2  <= 1'b0;
      r_err_p2  <= 1'b0;
    end else if (w_s2_adv) begin
      r_vld_p2 <= r_vld_p1;
      if (r_vld_p1) begin
        r_res_p2  <= w_res_p1;
        r_zero_p2 <= w_zero_p1;
        r_par_p2  <= w_par_p1;
        r_err_p2  <= w_err_p1;
      end
    end
  end

  assign out_valid = r_vld_p2;
  assign result    = r_res_p2;
  assign zero      = r_zero_p2;
  assign parity    = r_par_p2;
  assign err       = r_err_p2;

endmodule

// File: doc/alu_bool_pipe.md
ALU_BOOL_PIPE -- requirements
Module: alu_bool_pipe

Parameters
REQ-001 SHALL provide parameter WIDTH, default 32, operand/result width in bits (legal range 1..64).
REQ-002 SHALL provide parameter ERR_ON_ILLEGAL, default 1; 1 = flag illegal opcodes on err, 0 = err tied low.

Interface
REQ-003 SHALL provide clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL provide rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL provide A  input  WIDTH  operand A.
REQ-006 SHALL provide B  input  WIDTH  operand B.
REQ-007 SHALL provide opcode  input  3  operation select.
REQ-008 SHALL provide en  input  1  global pipeline enable; 0 freezes all state.
REQ-009 SHALL provide in_valid  input  1  A/B/opcode valid.
REQ-010 SHALL provide in_ready  output  1  block accepts input this cycle.
REQ-011 SHALL provide result  output  WIDTH  registered result.
REQ-012 SHALL provide zero  output  1  result == 0.
REQ-013 SHALL provide parity  output  1  XOR-reduction of result.
REQ-014 SHALL provide err  output  1  result came from illegal opcode.
REQ-015 SHALL provide out_valid  output  1  result/zero/parity/err valid.
REQ-016 SHALL provide out_ready  input  1  consumer accepts output this cycle.

Function
REQ-017 Opcode map SHALL be: 000 A^B, 001 A&B, 010 A|B, 011 ~(A^B), 100 ~(A&B), 101 ~(A|B), 110 A&~B; all bitwise over WIDTH bits.
REQ-018 Opcode 111 SHALL be illegal: result = 0, zero = 1, parity = 0, err = ERR_ON_ILLEGAL.
REQ-019 Pipeline SHALL be two register stages: S1 captures A, B, opcode; S2 holds computed result and flags.
REQ-020 Input transfer SHALL occur when in_valid & in_ready; output transfer when out_valid & out_ready.
REQ-021 Latency SHALL be 2 cycles: with en=1 and out_ready=1, an input accepted at edge N appears with out_valid=1 after edge N+1.
REQ-022 Throughput SHALL be one transfer per cycle when en=1 and out_ready=1.
REQ-023 S2 SHALL load from S1 when en=1 and (S2 empty or out_ready=1); S2 valid clears when it drains with S1 empty.
REQ-024 S1 SHALL load when en=1 and (S1 empty or S1 advancing into S2).
REQ-025 in_ready SHALL equal en & (~S1_valid | S2_load); combinational from out_ready, no bubble when draining.
REQ-026 When out_valid=1 and out_ready=0, result/zero/parity/err SHALL hold stable until transfer.
REQ-027 When en=0, in_ready SHALL be 0, no transfer SHALL occur on either side, all registers SHALL hold, out_valid SHALL hold its value.
REQ-028 Full pipeline (S1, S2 valid) with out_ready=0 SHALL deassert in_ready; no data SHALL be dropped or duplicated.
REQ-029 Simultaneous input and output transfer in the same cycle SHALL both complete.
REQ-030 in_valid=0 cycles SHALL insert bubbles that propagate; out_valid SHALL never be asserted for a bubble.
REQ-031 Flags SHALL be computed from the same result value presented on result in the same cycle.

Reset
REQ-032 With rst=1 at a rising edge, S1/S2 valid, out_valid, result, zero, parity, err SHALL be 0; rst overrides en.
REQ-033 During rst=1, in_ready SHALL be 0; in-flight data at reset SHALL be discarded.
REQ-034 First input SHALL be accepted on the first edge with rst=0, en=1, in_valid=1.

Verification
REQ-035 Op sweep, WIDTH=32: A=0xF0F0_1234, B=0x0FF0_FFFF, opcodes 000..110 back-to-back, out_ready=1 -> results 0xFF00_EDCB, 0x00F0_1234, 0xFFF0_FFFF, 0x00FF_1234, 0xFF0F_EDCB, 0x000F_0000, 0xF000_0000, one per cycle after 2-cycle latency.
REQ-036 Flags: A=B=0x5555_5555, op 000 -> result 0, zero=1, parity=0; op 001 -> zero=0, parity=0; A=0x1, B=0, op 010 -> parity=1.
REQ-037 Illegal: opcode 111, A=B=0xFFFF_FFFF -> result 0, zero=1, err=1 (ERR_ON_ILLEGAL=1); err=0 with ERR_ON_ILLEGAL=0.
REQ-038 Backpressure: stream 4 XOR ops, hold out_ready=0 from cycle 3 to 7 -> in_ready drops after 2 accepts, output stable, all 4 results delivered in order once out_ready=1.
REQ-039 Enable stall: en=0 for 3 cycles mid-stream -> in_ready=0, out_valid/result frozen, stream resumes without loss or duplication.
REQ-040 Reset mid-operation: rst=1 for 1 cycle with both stages valid -> next cycle out_valid=0, result=0, flags 0; subsequent input yields correct result at 2-cycle latency.
